ysyx_23060025_pipe_skid: RTL and testbench

//  Two-entry valid/ready pipeline register (skid buffer) between adjacent core stages (IF->ID, ID->EX, ...).

---
 rtl/ysyx_23060025_defs.sv | 35 +++
 rtl/ysyx_23060025_pipe_slot.sv | 58 +++++
 rtl/ysyx_23060025_pipe_skid.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060025_pipe_skid.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_defs.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_defs
//   Shared definitions for the core pipeline registers.
//   - Per-stage payload widths used when instantiating ysyx_23060025_pipe_skid
//     between adjacent stages.
//   - Skid-buffer state encoding, formed as {skid_valid, out_valid}.
//   - A helper function that flags the one unreachable encoding.
// ----------------------------------------------------------------------------
package ysyx_23060025_defs;

   // Payload widths of the inter-stage bundles (pc/inst/ctrl packed by the
   // producing stage).
   localparam int unsigned IF_ID_W  = 32'd64;
   localparam int unsigned ID_EX_W  = 32'd128;
   localparam int unsigned EX_MEM_W = 32'd96;
   localparam int unsigned MEM_WB_W = 32'd80;

   // State encoding {skid_valid, out_valid}.
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   typedef enum logic [1:0] {
      PS_EMPTY   = ST_EMPTY,
      PS_BUSY    = ST_BUSY,
      PS_ILLEGAL = 2'b10,
      PS_FULL    = ST_FULL
   } pipe_state_e;

   // A held overflow payload without a held main payload cannot happen.
   function automatic logic state_is_legal(input logic [1:0] st);
      return ~(st[1] & ~st[0]);
   endfunction

endpackage

// File: rtl/ysyx_23060025_pipe_slot.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_pipe_slot
//   One WIDTH-wide valid+data holding slot. The owner decides when to load or
//   clear; this module only stores.
// Ports
//   clock    in   1      posedge clock
//   reset    in   1      synchronous active-high; valid<=0, data<=RESET_VAL
//   load_i   in   1      capture data_i and mark the slot valid
//   clear_i  in   1      mark the slot empty (data kept); wins over load_i
//   data_i   in   WIDTH  payload to capture
//   valid_o  out  1      slot holds a payload
//   data_o   out  WIDTH  held payload
// ----------------------------------------------------------------------------
module ysyx_23060025_pipe_slot #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // Next-state selection for the slot.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else begin
         valid_d = valid_q;
      end
   end

   // Slot storage with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ysyx_23060025_pipe_skid.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_pipe_skid
//   Two-entry valid/ready pipeline register (skid buffer) between adjacent
//   core stages. Full throughput when downstream is ready; in_ready depends
//   only on held state and reset, so no ready path crosses the stage.
//   The main slot drives out_data directly; the skid slot only holds the
//   overflow payload that arrived while downstream stalled.
// Optional feature
//   PIPE_SKID_FLUSH_EN : when defined, flush=1 empties both slots (data regs
//   keep their values) and drops any simultaneous input transfer. When not
//   defined the flush port is present but ignored.
// Ports
//   clock      in   1      posedge clock
//   reset      in   1      synchronous active-high
//   in_valid   in   1      upstream has a payload
//   in_data    in   WIDTH  upstream payload
//   in_ready   out  1      stage accepts in_data this cycle
//   out_valid  out  1      out_data is valid
//   out_data   out  WIDTH  payload to downstream
//   out_ready  in   1      downstream accepts out_data this cycle
//   flush      in   1      discard all held payloads (feature-gated)
// ----------------------------------------------------------------------------
module ysyx_23060025_pipe_skid
   import ysyx_23060025_defs::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush
);

   logic             skid_valid_s;
   logic [WIDTH-1:0] skid_data_s;
   logic             main_valid_s;
   logic [WIDTH-1:0] main_data_s;

   logic             in_fire_s;
   logic             out_fire_s;
   logic             flush_s;
   pipe_state_e      state_s;

   logic             main_load_s;
   logic             main_clear_s;
   logic             main_from_skid_s;
   logic [WIDTH-1:0] main_in_s;
   logic             skid_load_s;
   logic             skid_clear_s;

`ifdef PIPE_SKID_FLUSH_EN
   assign flush_s = flush;
`else
   // Port kept for a uniform interface; its value never reaches the state.
   assign flush_s = flush & 1'b0;
`endif

   // Ready only depends on the held overflow slot, never on out_ready.
   assign in_ready   = ~skid_valid_s & ~reset;
   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = main_valid_s & out_ready;
   assign state_s    = pipe_state_e'({skid_valid_s, main_valid_s});

   // Slot load/clear selection for each state.
   always_comb begin
      main_load_s      = 1'b0;
      main_clear_s     = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      skid_clear_s     = 1'b0;
      if (flush_s) begin
         // Flush beats a simultaneous input transfer, which is dropped.
         main_clear_s = 1'b1;
         skid_clear_s = 1'b1;
      end else begin
         case (state_s)
            PS_EMPTY: begin
               if (in_fire_s) begin
                  main_load_s = 1'b1;
               end else begin
                  main_load_s = 1'b0;
               end
            end
            PS_BUSY: begin
               if (out_fire_s && in_fire_s) begin
                  main_load_s = 1'b1;
               end else if (out_fire_s) begin
                  main_clear_s = 1'b1;
               end else if (in_fire_s) begin
                  skid_load_s = 1'b1;
               end else begin
                  main_load_s = 1'b0;
               end
            end
            PS_FULL: begin
               // Drain: overflow payload moves up into the main slot.
               if (out_fire_s) begin
                  main_load_s      = 1'b1;
                  main_from_skid_s = 1'b1;
                  skid_clear_s     = 1'b1;
               end else begin
                  main_load_s = 1'b0;
               end
            end
            default: begin
               // Unreachable encoding: fall back to EMPTY.
               main_clear_s = 1'b1;
               skid_clear_s = 1'b1;
            end
         endcase
      end
   end

   assign main_in_s = main_from_skid_s ? skid_data_s : in_data;

   ysyx_23060025_pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clock   (clock),
      .reset   (reset),
      .load_i  (main_load_s),
      .clear_i (main_clear_s),
      .data_i  (main_in_s),
      .valid_o (main_valid_s),
      .data_o  (main_data_s)
   );

   ysyx_23060025_pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clock   (clock),
      .reset   (reset),
      .load_i  (skid_load_s),
      .clear_i (skid_clear_s),
      .data_i  (in_data),
      .valid_o (skid_valid_s),
      .data_o  (skid_data_s)
   );

   assign out_valid = main_valid_s;
   assign out_data  = main_data_s;

endmodule

// File: tb/tb_ysyx_23060025_pipe_skid.sv
module tb_ysyx_23060025_pipe_skid;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        flush;

   int tests_run;
   int tests_failed;
   bit mon_en;

   ysyx_23060025_pipe_skid #(
      .WIDTH     (32),
      .RESET_VAL (32'h0)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle past the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] id, input logic ordy);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
   endtask

   // State 10 (skid held without main) must never appear.
   always @(negedge clock) begin
      if (mon_en) begin
         check("legal_state", {31'd0, dut.skid_valid_s & ~dut.out_valid}, 32'd0);
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      mon_en       = 1'b0;
      reset        = 1'b1;
      flush        = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      // 1. reset three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_out_data", out_data, 32'h0);
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      end
      reset  = 1'b0;
      mon_en = 1'b1;
      #1;
      check("post_rst_in_ready", {31'd1 & 32'd0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // 2. full-throughput stream 1..8
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i[31:0], 1'b1);
         tick();
         check("stream_valid", {31'd0, out_valid}, 32'd1);
         check("stream_data", out_data, i[31:0]);
         check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      end
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("stream_drained", {31'd0, out_valid}, 32'd0);

      // 3. backpressure
      drive(1'b1, 32'hA, 1'b0);
      tick();
      check("bp_a_data", out_data, 32'hA);
      check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'hB, 1'b0);
      tick();
      check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_full_data", out_data, 32'hA);
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("bp_hold_data", out_data, 32'hA);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("bp_drain_b", out_data, 32'hB);
      check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      check("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("bp_empty", {31'd0, out_valid}, 32'd0);

      // 4. simultaneous in/out fire in BUSY
      drive(1'b1, 32'hC, 1'b0);
      tick();
      check("sim_c_data", out_data, 32'hC);
      drive(1'b1, 32'hD, 1'b1);
      tick();
      check("sim_d_data", out_data, 32'hD);
      check("sim_d_valid", {31'd0, out_valid}, 32'd1);
      check("sim_busy_skid", {31'd0, dut.skid_valid_s}, 32'd0);
      check("sim_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("sim_empty", {31'd0, out_valid}, 32'd0);

      // 5. reset while FULL with E/F held
      drive(1'b1, 32'hE, 1'b0);
      tick();
      drive(1'b1, 32'hF, 1'b0);
      tick();
      check("rf_full_in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      drive(1'b1, 32'h55, 1'b0);
      tick();
      check("rf_valid", {31'd0, out_valid}, 32'd0);
      check("rf_data", out_data, 32'h0);
      check("rf_in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rf_no_emit", {31'd0, out_valid}, 32'd0);
      end

      // 6. flush while FULL together with an input offer of 0x10
      drive(1'b1, 32'h20, 1'b0);
      tick();
      drive(1'b1, 32'h21, 1'b0);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h10, 1'b0);
      tick();
      flush = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      check("fl_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("fl_no_emit", {31'd0, out_valid}, 32'd0);
`else
      check("fl_off_data", out_data, 32'h20);
      check("fl_off_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("fl_off_drain", out_data, 32'h21);
      check("fl_off_drain_valid", {31'd0, out_valid}, 32'd1);
      tick();
      check("fl_off_empty", {31'd0, out_valid}, 32'd0);
`endif

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
